// File: rtl/thresh_param_loader.sv
// UART-fed threshold loader: parses A5/CMD/payload/XOR packets and commits
// new hue/sat/val/select parameters to the image-processing conduits atomically.
module thresh_param_loader #(
    parameter int unsigned   TIMEOUT_CYCLES = 5000000,
    parameter logic [143:0]  HUE_DEFAULT    = 144'h0,
    parameter logic [7:0]    SAT_DEFAULT    = 8'd80,
    parameter logic [7:0]    VAL_DEFAULT    = 8'd60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic [143:0]   threshue,
    output logic [7:0]     threshsat,
    output logic [7:0]     threshval,
    output logic [3:0]     thresholdsig,
    output logic           mode_1,
    output logic           update_pulse,
    output logic [7:0]     err_cnt
);

    localparam int unsigned TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CW        = 5;
    localparam int unsigned HUE_W     = 144;
    localparam logic [7:0]  HDR_BYTE  = 8'hA5;
    localparam logic [7:0]  CMD_HUE   = 8'h01;
    localparam logic [7:0]  CMD_SV    = 8'h02;
    localparam logic [7:0]  CMD_SIG   = 8'h03;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        CHECK,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [HUE_W-1:0]    stage_q;
    logic [7:0]          xor_q;
    logic [7:0]          cmd_q;
    logic [CW-1:0]       cnt_q;
    logic [TW-1:0]       tmo_q;

    logic                accept_c;
    logic                tmo_hit_c;
    logic                err_c;
    logic                cmd_ok_c;
    logic [CW-1:0]       cmd_len_c;

    // Payload length per command; zero marks an unknown command.
    always_comb begin
        cmd_len_c = '0;
        unique case (rx_data)
            CMD_HUE: cmd_len_c = CW'(18);
            CMD_SV:  cmd_len_c = CW'(2);
            CMD_SIG: cmd_len_c = CW'(1);
            default: cmd_len_c = '0;
        endcase
        cmd_ok_c = (cmd_len_c != '0);
    end

    assign accept_c  = rx_valid && rx_ready;
    assign tmo_hit_c = (tmo_q == TMO_LAST);

    // Next-state logic; an accepted byte always wins over a timeout.
    always_comb begin
        state_d = state_q;
        err_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_c && rx_data == HDR_BYTE) state_d = CMD;
            end
            CMD: begin
                if (accept_c) begin
                    if (cmd_ok_c) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = IDLE;
                        err_c   = 1'b1;
                    end
                end else if (tmo_hit_c) begin
                    state_d = IDLE;
                    err_c   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (accept_c) begin
                    if (cnt_q == CW'(1)) state_d = CHECK;
                end else if (tmo_hit_c) begin
                    state_d = IDLE;
                    err_c   = 1'b1;
                end
            end
            CHECK: begin
                if (accept_c) begin
                    if (rx_data == xor_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_c   = 1'b1;
                    end
                end else if (tmo_hit_c) begin
                    state_d = IDLE;
                    err_c   = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus ready/pulse flags derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_ready     <= 1'b1;
            update_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_ready     <= (state_d != COMMIT);
            update_pulse <= (state_q == COMMIT);
        end
    end

    // Idle-gap counter: runs only while a packet is partially received.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (accept_c || state_d == IDLE || state_d == COMMIT) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Staging path: payload shifts in MSB-first, checksum accumulates over CMD+payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
            xor_q   <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else if (state_d == IDLE) begin
            stage_q <= '0;
            xor_q   <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else if (accept_c) begin
            if (state_q == CMD) begin
                cmd_q <= rx_data;
                xor_q <= rx_data;
                cnt_q <= cmd_len_c;
            end else if (state_q == PAYLOAD) begin
                stage_q <= {stage_q[HUE_W-9:0], rx_data};
                xor_q   <= xor_q ^ rx_data;
                cnt_q   <= cnt_q - CW'(1);
            end
        end
    end

    // Committed parameter registers; only the addressed fields change.
    always_ff @(posedge clk) begin
        if (reset) begin
            threshue     <= HUE_DEFAULT;
            threshsat    <= SAT_DEFAULT;
            threshval    <= VAL_DEFAULT;
            thresholdsig <= '0;
            mode_1       <= 1'b0;
        end else if (state_q == COMMIT) begin
            unique case (cmd_q)
                CMD_HUE: threshue <= stage_q;
                CMD_SV: begin
                    threshsat <= stage_q[15:8];
                    threshval <= stage_q[7:0];
                end
                CMD_SIG: begin
                    thresholdsig <= stage_q[3:0];
                    mode_1       <= stage_q[4];
                end
                default: ;
            endcase
        end
    end

    // Saturating count of rejected and aborted packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_c && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_thresh_param_loader.sv
// Randomised plus directed bench for thresh_param_loader against a byte-stream packet model.
module tb_thresh_param_loader;

    localparam int unsigned TMO = 16;
    localparam logic [7:0]  SAT_DEF = 8'd80;
    localparam logic [7:0]  VAL_DEF = 8'd60;

    logic           clk;
    logic           reset;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [143:0]   threshue;
    logic [7:0]     threshsat;
    logic [7:0]     threshval;
    logic [3:0]     thresholdsig;
    logic           mode_1;
    logic           update_pulse;
    logic [7:0]     err_cnt;

    thresh_param_loader #(
        .TIMEOUT_CYCLES (TMO),
        .HUE_DEFAULT    (144'h0),
        .SAT_DEFAULT    (SAT_DEF),
        .VAL_DEFAULT    (VAL_DEF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .threshue     (threshue),
        .threshsat    (threshsat),
        .threshval    (threshval),
        .thresholdsig (thresholdsig),
        .mode_1       (mode_1),
        .update_pulse (update_pulse),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the packet is the list of bytes collected so far.
    logic [7:0]   m_pkt[$];
    int           m_idle;
    bit           m_commit;
    logic [143:0] m_hue;
    logic [7:0]   m_sat, m_val;
    logic [3:0]   m_sig;
    logic         m_mode;
    logic         m_pulse;
    int           m_err;

    function automatic int plen(input logic [7:0] c);
        case (c)
            8'h01:   return 18;
            8'h02:   return 2;
            8'h03:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic void m_bump_err();
        if (m_err < 255) m_err++;
        m_pkt.delete();
        m_idle = 0;
    endfunction

    function automatic void m_apply();
        int n = plen(m_pkt[1]);
        if (n == 18) begin
            for (int i = 0; i < 18; i++) m_hue = {m_hue[135:0], m_pkt[2+i]};
        end else if (n == 2) begin
            m_sat = m_pkt[2];
            m_val = m_pkt[3];
        end else begin
            m_sig  = m_pkt[2][3:0];
            m_mode = m_pkt[2][4];
        end
    endfunction

    function automatic void model_step(input logic r, input logic v, input logic [7:0] d);
        logic [7:0] x;
        if (r) begin
            m_pkt.delete();
            m_idle = 0; m_commit = 0; m_pulse = 0; m_err = 0;
            m_hue = '0; m_sat = SAT_DEF; m_val = VAL_DEF; m_sig = '0; m_mode = 0;
            return;
        end
        m_pulse = m_commit;
        if (m_commit) begin
            m_apply();
            m_pkt.delete();
            m_commit = 0;
            m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            if (m_pkt.size() == 0) begin
                if (d == 8'hA5) m_pkt.push_back(d);
            end else begin
                m_pkt.push_back(d);
                if (m_pkt.size() == 2 && plen(d) == 0) begin
                    m_bump_err();
                end else if (m_pkt.size() == plen(m_pkt[1]) + 3) begin
                    x = '0;
                    for (int i = 1; i < m_pkt.size() - 1; i++) x ^= m_pkt[i];
                    if (x == d) m_commit = 1;
                    else m_bump_err();
                end
            end
        end else if (m_pkt.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) m_bump_err();
        end else begin
            m_idle = 0;
        end
    endfunction

    task automatic cycle(input logic v, input logic [7:0] d, input logic r = 1'b0);
        rx_valid = v;
        rx_data  = d;
        reset    = r;
        @(posedge clk);
        model_step(r, v, d);
        #1;
        check("rx_ready",     144'(rx_ready),     144'(!m_commit));
        check("threshue",     threshue,           m_hue);
        check("threshsat",    144'(threshsat),    144'(m_sat));
        check("threshval",    144'(threshval),    144'(m_val));
        check("thresholdsig", 144'(thresholdsig), 144'(m_sig));
        check("mode_1",       144'(mode_1),       144'(m_mode));
        check("update_pulse", 144'(update_pulse), 144'(m_pulse));
        check("err_cnt",      144'(err_cnt),      144'(m_err));
    endtask

    logic [7:0] pkt[$];

    task automatic send_pkt(input int maxgap, input int tail);
        foreach (pkt[i]) begin
            cycle(1'b1, pkt[i]);
            repeat ($urandom_range(maxgap, 0)) cycle(1'b0, 8'h00);
        end
        repeat (tail) cycle(1'b0, 8'h00);
    endtask

    task automatic build_valid(input logic [7:0] c);
        logic [7:0] x;
        logic [7:0] b;
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(c);
        x = c;
        for (int i = 0; i < plen(c); i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            x ^= b;
        end
        pkt.push_back(x);
    endtask

    initial begin
        logic [7:0]   k;
        logic [143:0] hue_exp;
        clk = 0; reset = 1; rx_valid = 0; rx_data = '0;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("rst_err", 144'(err_cnt), 144'(0));
        check("rst_sat", 144'(threshsat), 144'(SAT_DEF));
        check("rst_val", 144'(threshval), 144'(VAL_DEF));
        check("rst_rdy", 144'(rx_ready), 144'(1));

        // sat/val update
        pkt = '{8'hA5, 8'h02, 8'h64, 8'h32, 8'h54};
        send_pkt(0, 0);
        check("sv_pre_sat", 144'(threshsat), 144'(SAT_DEF));
        check("sv_commit_rdy", 144'(rx_ready), 144'(0));
        cycle(1'b0, 8'h00);
        check("sv_sat", 144'(threshsat), 144'(8'h64));
        check("sv_val", 144'(threshval), 144'(8'h32));
        check("sv_pulse", 144'(update_pulse), 144'(1));
        check("sv_hue", threshue, 144'h0);
        check("sv_sig", 144'({mode_1, thresholdsig}), 144'(0));
        cycle(1'b0, 8'h00);
        check("sv_pulse_off", 144'(update_pulse), 144'(0));

        // select / mode
        pkt = '{8'hA5, 8'h03, 8'h15, 8'h16};
        send_pkt(0, 2);
        check("sig_a", 144'(thresholdsig), 144'(4'h5));
        check("mode_a", 144'(mode_1), 144'(1));
        pkt = '{8'hA5, 8'h03, 8'hE0, 8'hE3};
        send_pkt(0, 2);
        check("sig_b", 144'(thresholdsig), 144'(4'h0));
        check("mode_b", 144'(mode_1), 144'(0));

        // hue table, with an embedded A5 treated as data via the random path later
        pkt.delete();
        pkt.push_back(8'hA5); pkt.push_back(8'h01);
        hue_exp = '0;
        for (int i = 1; i <= 18; i++) begin
            k = 8'(i);
            pkt.push_back(k);
            hue_exp = {hue_exp[135:0], k};
        end
        pkt.push_back(8'h12);
        send_pkt(0, 0);
        check("hue_pre", threshue, 144'h0);
        cycle(1'b0, 8'h00);
        check("hue", threshue, hue_exp);
        check("hue_sat_keep", 144'(threshsat), 144'(8'h64));

        // bad checksum, then bad command
        pkt = '{8'hA5, 8'h02, 8'h64, 8'h32, 8'h55};
        send_pkt(0, 2);
        check("badck_err", 144'(err_cnt), 144'(1));
        pkt = '{8'hA5, 8'h07};
        send_pkt(0, 1);
        check("badcmd_err", 144'(err_cnt), 144'(2));

        // timeout
        cycle(1'b0, 8'h00, 1'b1);
        pkt = '{8'hA5, 8'h02, 8'h64};
        send_pkt(0, 15);
        check("tmo_early", 144'(err_cnt), 144'(0));
        cycle(1'b0, 8'h00);
        check("tmo_err", 144'(err_cnt), 144'(1));
        pkt = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
        send_pkt(0, 2);
        check("tmo_after_sat", 144'(threshsat), 144'(8'h11));

        // reset mid-packet
        pkt = '{8'hA5, 8'h02, 8'h64};
        send_pkt(0, 0);
        cycle(1'b0, 8'h00, 1'b1);
        check("mid_rst_sat", 144'(threshsat), 144'(SAT_DEF));
        check("mid_rst_err", 144'(err_cnt), 144'(0));
        pkt = '{8'h32, 8'h54};
        send_pkt(0, 2);
        check("mid_rst_keep", 144'(threshsat), 144'(SAT_DEF));

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            int kind = $urandom_range(9, 0);
            if (kind <= 4) begin
                build_valid(8'($urandom_range(3, 1)));
            end else if (kind == 5) begin
                build_valid(8'($urandom_range(3, 1)));
                pkt[pkt.size()-1] ^= 8'($urandom_range(255, 1));
            end else if (kind == 6) begin
                pkt = '{8'hA5, 8'($urandom_range(255, 4))};
            end else if (kind == 7) begin
                pkt = '{8'($urandom), 8'($urandom)};
            end else begin
                build_valid(8'($urandom_range(3, 1)));
                pkt = pkt[0:$urandom_range(pkt.size()-2, 1)];
                send_pkt(2, TMO + 1);
                continue;
            end
            if ($urandom_range(30, 0) == 0) cycle(1'b0, 8'h00, 1'b1);
            send_pkt(2, $urandom_range(3, 1));
        end

        // err_cnt saturation
        cycle(1'b0, 8'h00, 1'b1);
        pkt = '{8'hA5, 8'h07};
        for (int n = 0; n < 260; n++) send_pkt(0, 0);
        cycle(1'b0, 8'h00);
        check("err_sat", 144'(err_cnt), 144'(255));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thresh_param_loader.md
THRESH_PARAM_LOADER -- requirements
Module: thresh_param_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter list (name, default, meaning):
- TIMEOUT_CYCLES, 5000000, idle cycles between accepted bytes before a partial packet is aborted (100 ms at 50 MHz).
- HUE_DEFAULT, 144'h0, reset value of threshue.
- SAT_DEFAULT, 8'd80, reset value of threshsat.
- VAL_DEFAULT, 8'd60, reset value of threshval.
REQ-003 Port list (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous active-high reset.
- rx_data, in, 8, byte from the UART receive path.
- rx_valid, in, 1, rx_data is valid.
- rx_ready, out, 1, block accepts the byte this cycle.
- threshue, out, 144, hue threshold table to the eee_imgproc custom_threshue conduit.
- threshsat, out, 8, saturation threshold to the custom_threshsat conduit.
- threshval, out, 8, value threshold to the custom_threshval conduit.
- thresholdsig, out, 4, select to the custom_thresholdsig conduit.
- mode_1, out, 1, mode flag to the mode_1 conduit.
- update_pulse, out, 1, one-cycle strobe on every committed update.
- err_cnt, out, 8, count of rejected or aborted packets.

Function
REQ-004 A byte SHALL be accepted only in a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 in every state except COMMIT.
REQ-005 Packet format: 0xA5 header, CMD byte, payload, checksum; checksum = XOR of CMD and all payload bytes.
REQ-006 Commands and payload lengths:
- 0x01: 18 bytes, first byte goes to threshue[143:136], continuing MSB-first.
- 0x02: 2 bytes, threshsat then threshval.
- 0x03: 1 byte, bits[3:0] go to thresholdsig and bit4 goes to mode_1; bits[7:5] are ignored.
REQ-007 FSM states: IDLE, CMD, PAYLOAD, CHECK, COMMIT.
- IDLE: an accepted 0xA5 goes to CMD; any other accepted byte is discarded silently.
- CMD: a valid CMD goes to PAYLOAD with the byte count loaded; an invalid CMD increments err_cnt and goes to IDLE.
- PAYLOAD: each accepted byte is written into the staging register; the last byte goes to CHECK.
- CHECK: an accepted byte equal to the running XOR goes to COMMIT; a mismatch increments err_cnt and goes to IDLE.
- COMMIT: lasts one cycle, then goes to IDLE.
REQ-008 The payload SHALL be held in staging registers; the outputs SHALL NOT change before COMMIT.
REQ-009 In COMMIT the block SHALL copy staging into only the fields addressed by CMD, all in the same cycle. The outputs SHALL show the new values, with update_pulse=1, in the cycle after COMMIT; fields not addressed keep their values.
REQ-010 A 0xA5 byte received in CMD, PAYLOAD or CHECK SHALL be treated as data and SHALL NOT resynchronise the packet.
REQ-011 Timeout counter:
- It SHALL clear on every accepted byte and on entry to IDLE.
- It SHALL count in CMD, PAYLOAD and CHECK.
- On reaching TIMEOUT_CYCLES-1 the block SHALL go to IDLE, discard staging and increment err_cnt.
- If a byte is accepted in the same cycle, the byte SHALL take priority and no timeout occurs.
REQ-012 err_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-013 update_pulse SHALL be high for exactly one cycle per commit and low at all other times.

Reset
REQ-014 On reset:
- FSM goes to IDLE; staging, the XOR accumulator, the byte counter and the timeout counter clear.
- rx_ready=1, update_pulse=0, err_cnt=0.
- threshue=HUE_DEFAULT, threshsat=SAT_DEFAULT, threshval=VAL_DEFAULT, thresholdsig=0, mode_1=0.
REQ-015 A reset asserted mid-packet SHALL abandon the packet with no output update and no err_cnt increment.

Verification
REQ-016 The bench SHALL cover:
- Send A5 02 64 32 54 -> one cycle after COMMIT: threshsat=0x64, threshval=0x32, update_pulse high for 1 cycle; threshue, thresholdsig and mode_1 unchanged.
- Send A5 03 15 16 -> thresholdsig=0x5, mode_1=1; then A5 03 E0 E3 -> thresholdsig=0x0, mode_1=0.
- Send A5 01, bytes 0x01..0x12, checksum 0x12 -> threshue=144'h0102...12; no output changes before COMMIT.
- Send A5 02 64 32 55 (bad checksum) -> outputs unchanged, err_cnt=1, no update_pulse; then A5 07 -> err_cnt=2.
- With TIMEOUT_CYCLES=16, send A5 02 64 then stall -> abort after 16 idle cycles, err_cnt=1; then a full valid packet commits normally.
- Assert reset after A5 02 64 -> all outputs at defaults, err_cnt=0; 260 bad packets -> err_cnt=255.
